// File: rtl/simple_module_pkg.sv
// Purpose : shared defaults and the saturating-increment helper for simple_module.
// Latency : n/a (package only).
// Backpressure: n/a.
package simple_module_pkg;

  // Default parameter values used by simple_module and sat_counter.
  localparam int          DEF_WIDTH   = 1;
  localparam logic [63:0] DEF_RST_VAL = 64'd0;
  localparam int          DEF_CNT_W   = 8;

  // Saturating increment of a value that is 'width' bits wide (1..64),
  // carried in a 64-bit container. At the all-ones value for that width
  // the result stays put instead of wrapping.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int width);
    logic [63:0] max_val;
    max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (val >= max_val) ? max_val : (val + 64'd1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Purpose : saturating up-counter, cleared by synchronous reset.
// Latency : count reflects an inc one clk after the edge that sampled it.
// Backpressure: none; inc is accepted every cycle, the count simply stops at all-ones.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high clear
//   inc   - increment request for this edge
//   count - current count (CNT_W bits, 1..64)
module sat_counter
  import simple_module_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Power-up value matches the reset value so the count reads 0 before
  // the first reset as well.
  logic [CNT_W-1:0] count_r = '0;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = CNT_W'(sat_inc(64'(count_r), CNT_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (inc) begin
      count_r <= count_nxt;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/simple_module.sv
// Purpose : enable-gated data register with change pulse and saturating load counter.
// Latency : one clk from (en, d) to q / q_changed / update_count; no comb path from inputs.
// Backpressure: none; a load is taken on every edge where en is high.
//
// Ports:
//   clk          - clock, rising edge
//   rst          - synchronous active-high reset (floating/Z behaves as inactive)
//   en           - load enable
//   d            - data to capture (WIDTH bits)
//   q            - registered data, RST_VAL at power-up and after reset
//   q_changed    - one-cycle pulse after a load that changed q
//   update_count - saturating count of enabled loads since reset
module simple_module
  import simple_module_pkg::*;
#(
  parameter int               WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = DEF_RST_VAL[WIDTH-1:0],
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             q_changed,
  output logic [CNT_W-1:0] update_count
);

  // Registers carry their power-up values directly; the FPGA flow honours
  // declaration initialisers.
  logic [WIDTH-1:0] q_r         = RST_VAL;
  logic             q_changed_r = 1'b0;

  // A floating rst reads as X/Z; 'if (rst)' then takes the else branch, so
  // an unconnected reset behaves as inactive.
  logic load;
  assign load = en && !rst;

  // Data register. d is copied as-is so X/Z on d shows up on q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= RST_VAL;
    end else if (en) begin
      q_r <= d;
    end
  end

  // Change pulse: compares against the q value held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_changed_r <= 1'b0;
    end else begin
      q_changed_r <= en && (d != q_r);
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_update_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (load),
    .count (update_count)
  );

  assign q         = q_r;
  assign q_changed = q_changed_r;

endmodule

// File: tb/tb_simple_module.sv
module tb_simple_module;

  logic clk;

  // DUT A: defaults (WIDTH=1, CNT_W=8)
  logic       rst_a, en_a, d_a;
  logic       q_a, qc_a;
  logic [7:0] cnt_a;

  // DUT B: CNT_W=3 for saturation
  logic       rst_b, en_b, d_b;
  logic       q_b, qc_b;
  logic [2:0] cnt_b;

  // DUT C: WIDTH=8, RST_VAL=8'hA5
  logic       rst_c, en_c;
  logic [7:0] d_c, q_c;
  logic       qc_c;
  logic [7:0] cnt_c;

  int checks;
  int failures;

  simple_module u_dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .en           (en_a),
    .d            (d_a),
    .q            (q_a),
    .q_changed    (qc_a),
    .update_count (cnt_a)
  );

  simple_module #(
    .CNT_W (3)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .en           (en_b),
    .d            (d_b),
    .q            (q_b),
    .q_changed    (qc_b),
    .update_count (cnt_b)
  );

  simple_module #(
    .WIDTH   (8),
    .RST_VAL (8'hA5)
  ) u_dut_c (
    .clk          (clk),
    .rst          (rst_c),
    .en           (en_c),
    .d            (d_c),
    .q            (q_c),
    .q_changed    (qc_c),
    .update_count (cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic eq, input logic eqc, input int ecnt);
    chk({tag, ".q"},   64'(q_a),   64'(eq));
    chk({tag, ".qc"},  64'(qc_a),  64'(eqc));
    chk({tag, ".cnt"}, 64'(cnt_a), 64'(ecnt));
  endtask

  task automatic check_c(input string tag, input logic [7:0] eq, input logic eqc, input int ecnt);
    chk({tag, ".q"},   64'(q_c),   64'(eq));
    chk({tag, ".qc"},  64'(qc_c),  64'(eqc));
    chk({tag, ".cnt"}, 64'(cnt_c), 64'(ecnt));
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] tog_q;
    logic [9:0] tog_qc;
    int         tog_cnt[10];
    int         sat_cnt[10];
    logic       new_en, new_d;

    checks   = 0;
    failures = 0;
    rst_a = 1'b0; en_a = 1'b0; d_a = 1'b0;
    rst_b = 1'b0; en_b = 1'b0; d_b = 1'b0;
    rst_c = 1'b0; en_c = 1'b0; d_c = 8'h00;

    // Power-up values, before any edge and before any reset.
    #1;
    check_a("pwrup_a", 1'b0, 1'b0, 0);
    chk("pwrup_b.cnt", 64'(cnt_b), 64'd0);
    check_c("pwrup_c", 8'hA5, 1'b0, 0);

    // Idle: en low, d toggling, no reset yet.
    for (int i = 0; i < 3; i++) begin
      d_a = ~d_a;
      d_c = ~d_c;
      tick();
      check_a($sformatf("idle%0d", i), 1'b0, 1'b0, 0);
      chk($sformatf("idle%0d_c.q", i), 64'(q_c), 64'hA5);
    end

    // Toggle sequence: (en,d) at the edges = 00,01,11,10,00,01,11,10,00,01.
    tog_q   = 10'b0001000100;
    tog_qc  = 10'b0011001100;
    tog_cnt = '{0, 0, 1, 2, 2, 2, 3, 4, 4, 4};
    en_a = 1'b0; d_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_a($sformatf("tog%0d", i), tog_q[i], tog_qc[i], tog_cnt[i]);
      new_en = d_a;
      new_d  = ~en_a;
      en_a   = new_en;
      d_a    = new_d;
    end

    // Reset clears everything, regardless of en/d.
    rst_a = 1'b1; en_a = 1'b0; d_a = 1'b1;
    tick();
    check_a("rst1", 1'b0, 1'b0, 0);

    // Hold: one load of 1, then en low for 4 cycles.
    rst_a = 1'b0; en_a = 1'b1; d_a = 1'b1;
    tick();
    check_a("hold_ld", 1'b1, 1'b1, 1);
    en_a = 1'b0; d_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_a($sformatf("hold%0d", i), 1'b1, 1'b0, 1);
    end

    // Reloading the same value counts but does not pulse q_changed.
    en_a = 1'b1; d_a = 1'b1;
    tick();
    check_a("same_ld", 1'b1, 1'b0, 2);

    // rst pulse between edges has no effect.
    en_a = 1'b0;
    rst_a = 1'b1;
    #2;
    rst_a = 1'b0;
    #1;
    chk("midrst.q_now", 64'(q_a), 64'd1);
    tick();
    check_a("midrst", 1'b1, 1'b0, 2);

    // Reset wins over en at the same edge.
    rst_a = 1'b1; en_a = 1'b1; d_a = 1'b1;
    tick();
    check_a("rst_prio", 1'b0, 1'b0, 0);

    // First edge after reset release is a normal load.
    rst_a = 1'b0;
    tick();
    check_a("post_rst", 1'b1, 1'b1, 1);
    en_a = 1'b0;

    // Saturation on the 3-bit counter.
    rst_b = 1'b1;
    tick();
    chk("sat_rst.cnt", 64'(cnt_b), 64'd0);
    rst_b = 1'b0; en_b = 1'b1; d_b = 1'b1;
    sat_cnt = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("sat%0d.cnt", i), 64'(cnt_b), 64'(sat_cnt[i]));
    end
    en_b = 1'b0;

    // Wide data with a non-zero reset value.
    d_c = 8'h11;
    rst_c = 1'b1; en_c = 1'b1;
    tick();
    check_c("wide_rst", 8'hA5, 1'b0, 0);
    rst_c = 1'b0; en_c = 1'b1; d_c = 8'h3C;
    tick();
    check_c("wide_ld", 8'h3C, 1'b1, 1);
    en_c = 1'b0; d_c = 8'hFF;
    tick();
    check_c("wide_hold", 8'h3C, 1'b0, 1);
    en_c = 1'b1; d_c = 8'h3C;
    tick();
    check_c("wide_same", 8'h3C, 1'b0, 2);
    en_c = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete within 20000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/simple_module.md
SIMPLE_MODULE -- requirements
Module: simple_module

Interface
REQ-001 Parameter WIDTH, default 1: width of d and q, legal range 1..64.
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits): value loaded into q on reset and used as power-up value.
REQ-003 Parameter CNT_W, default 8: width of update_count.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high; an unconnected rst (high-Z) SHALL act as inactive.
REQ-006 en  input  1  load enable; when high, d is captured at the next rising clk edge.
REQ-007 d  input  WIDTH  data to capture.
REQ-008 q  output  WIDTH  registered data.
REQ-009 q_changed  output  1  registered pulse, high for one cycle after a load that changed q.
REQ-010 update_count  output  CNT_W  saturating count of enabled loads since reset.
REQ-011 Outputs q_changed and update_count MAY be left unconnected; a bench connecting only clk, en, d and q SHALL see full q behaviour.

Function
REQ-012 At each rising clk edge with rst low and en high, q SHALL take the value of d sampled at that edge.
  - Latency is one cycle: the new q is visible after the edge and stable until the next edge.
REQ-013 At each rising clk edge with rst low and en low, q SHALL hold its previous value.
REQ-014 No combinational path SHALL exist from d or en to any output.
REQ-015 q_changed SHALL be set to 1 at an edge where en=1, rst=0 and d differs from the current q, and SHALL be 0 at every other edge.
REQ-016 update_count SHALL increment by 1 at each edge where en=1 and rst=0.
  - It SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-017 A load of a value equal to the current q SHALL increment update_count and SHALL leave q_changed at 0.
REQ-018 X or Z on d with en=1 SHALL propagate to q; no masking is required.
REQ-019 Before the first reset, q SHALL hold its power-up value RST_VAL, q_changed SHALL be 0 and update_count SHALL be 0.
  - This requires initial values on the registers, which the target FPGA flow supports.

Reset
REQ-020 At a rising clk edge with rst=1, the outputs SHALL be set as follows, regardless of en and d:
  - q to RST_VAL;
  - q_changed to 0;
  - update_count to 0.
REQ-021 Reset SHALL take priority over en when both are high at the same edge.
REQ-022 Assertion of rst between clock edges SHALL have no effect until the next rising edge; there is no asynchronous path.
REQ-023 The first edge after rst falls SHALL behave as a normal cycle and honour en.

Structure
REQ-024 A shared package simple_module_pkg SHALL hold the following:
  - the default values of WIDTH, RST_VAL and CNT_W;
  - a function for saturating increment.
REQ-025 One sub-module, sat_counter (parameter CNT_W, inputs clk, rst and inc, output count), SHALL implement update_count.
  - The q and q_changed registers SHALL live in simple_module itself.
REQ-026 There SHALL be one always block per register group.
  - Sequential logic SHALL use non-blocking assignment only.

Verification
REQ-027 Idle: rst=0, en=0, d toggling for 3 cycles after power-up.
  - Required response: q=0, q_changed=0 and update_count=0 throughout.
REQ-028 Toggle sequence: start from en=0, d=0; at each edge drive en<=d and d<=~en, so (en,d) follows 00,01,11,10,00...
  - Run 10 cycles.
  - Required response: q updates only on cycles where en=1, to that cycle's d, i.e. q goes 1 then 0, repeating.
REQ-029 Hold: load d=1 with en=1, then hold en=0 with d=0 for 4 cycles.
  - Required response: q stays 1; update_count=1.
  - q_changed is high for exactly one cycle.
REQ-030 Reset priority: q=1, then apply rst=1, en=1, d=1 at the same edge.
  - Required response: q=0, update_count=0, q_changed=0.
  - rst pulsed mid-cycle without an edge leaves q unchanged.
REQ-031 Saturation: CNT_W=3, en=1 for 10 cycles.
  - Required response: update_count reads 1..7, then remains 7.
REQ-032 Wide data: WIDTH=8, RST_VAL=8'hA5.
  - Required response: after reset q=8'hA5.
  - Loading d=8'h3C with en=1 gives q=8'h3C one cycle later.
